blur_filter: RTL and testbench
==============================

# blur_filter

Per-pixel 3x3 smoothing stage directly downstream of the line read buffer. It captures the 216-bit 3x3 window the buffer presents and computes a Gaussian blur (kernel 1 2 1 / 2 4 2 / 1 2 1, divided by 16) on each 8-bit colour channel. It emits one 24-bit filtered pixel, then pulses `pixel_done` back to the read buffer so the buffer advances its window column. An optional Sobel edge stage forces detected edges to black, which produces the cartoon outline.

## Interface
- `EDGE_THRESH`, default 11'd255: Sobel magnitude at or above which a pixel is an edge. Used only when `BLUR_EDGE_EN` is defined.
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `filter_start` in 1: request to filter the window currently on `pixelData`.
- `pixelData` in 216: 3x3 window.
  - Row r occupies bits [72r+71:72r]; row 0 is the newest line.
  - Within a row, column 0 is the top 24 bits.
  - Each pixel is {R[23:16], G[15:8], B[7:0]}.
- `pixel_done` out 1: one-cycle pulse when the result is valid; advances the read buffer window.
- `filtered_pixel` out 24: result pixel, same channel layout as the input.
- `filtered_valid` out 1: `filtered_pixel` is valid for this cycle.
- `edge_flag` out 1: the result was forced black by the edge stage.
- `busy` out 1: the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ROW0, ROW1, ROW2, OUT.
- IDLE
  - `filter_start`=1 latches `pixelData` into an internal window register, clears the accumulators, and moves to ROW0.
  - `filter_start`=0 stays in IDLE.
- ROWk (k = 0, 1, 2): each channel accumulator adds that row's weighted sum, then the FSM advances.
  - Weights are (1,2,4,2,1 per kernel position), i.e. rows 0 and 2 use 1,2,1 and row 1 uses 2,4,2.
  - Multiplication is by shift only.
  - ROW2 moves to OUT.
- ROW2 to OUT transition registers the result.
  - Each channel result is (acc + 8) >> 4.
  - The accumulator is 12 bits unsigned (maximum 4080), so no saturation is needed.
- OUT: `filtered_valid`=1 and `pixel_done`=1, then the FSM returns to IDLE unconditionally.
- `filter_start` outside IDLE, including in OUT, is ignored and not queued.
- `filtered_pixel` and `edge_flag` hold their last value until the next OUT update.
- Asynchronous reset at any time:
  - FSM returns to IDLE.
  - Accumulators and the window register clear.
  - The in-flight pixel is discarded and no `pixel_done` is issued.

## Timing
- Values after reset: `pixel_done`=0, `filtered_valid`=0, `busy`=0, `filtered_pixel`=24'h0, `edge_flag`=0.
- `filter_start` is sampled at edge N.
  - `busy`=1 during cycles N+1 through N+4.
  - `filtered_valid` and `pixel_done` are high only during cycle N+4.
- Latency is 4 cycles; throughput is one pixel per 5 cycles at most.
- `pixelData` needs to be stable only at the `filter_start` edge. The read buffer may shift its window from cycle N+1 on.
- `pixel_done` is a single-cycle pulse, which matches the read buffer's count_enable usage.

## Configuration
- Macro `BLUR_EDGE_EN`.
- When defined:
  - Per pixel, compute luma Y = (R + 2G + B) >> 2 (8 bits).
  - Accumulate the Sobel terms row by row in the same ROWk states:
    - Gx = right column minus left column, with weights 1,2,1. Signed 11 bits, range ±1020.
    - Gy = row 2 minus row 0, with weights 1,2,1.
  - In OUT, if |Gx| + |Gy| (11 bits unsigned) is at least `EDGE_THRESH`:
    - `filtered_pixel` = 24'h000000 and `edge_flag`=1.
  - Otherwise the blur result is output and `edge_flag`=0.
  - Latency is unchanged.
- When not defined: no luma or Sobel logic is built, `edge_flag` is tied to 0, and `EDGE_THRESH` is unused.

## Structure
- Package `blur_pkg` holds:
  - the state enum `blur_state_t`;
  - the `pixel_t` struct {r, g, b};
  - the kernel weight constants;
  - the width constants `ACC_W`=12 and `GRAD_W`=11.
- Sub-module `channel_row_acc`: one-channel row multiply-accumulate (weights 1,2,1 or 2,4,2 chosen by row, clear, enable). It is instantiated three times, once for R, G and B.

## Test plan
- Uniform window, all pixels 24'h808080, start pulsed:
  - `filtered_pixel`=24'h808080 with `edge_flag`=0.
  - `filtered_valid`/`pixel_done` high exactly at cycle N+4, for 1 cycle.
- Centre pixel 24'hFFFFFF, all others 0: `filtered_pixel`=24'h404040, from (1020+8)>>4=64.
- All pixels 24'hFFFFFF: `filtered_pixel`=24'hFFFFFF, confirming no overflow at accumulator maximum 4080.
- Left column 24'hFFFFFF, others 0, default `EDGE_THRESH`:
  - With `BLUR_EDGE_EN`: |Gx|=1020, so `filtered_pixel`=24'h000000 and `edge_flag`=1.
  - Without it: 24'h404040 and `edge_flag`=0.
- `filter_start` held high for 12 cycles: exactly two results.
  - Starts are accepted at N and N+5.
  - `pixel_done` pulses at N+4 and N+9.
  - `pixelData` changed after each accept does not corrupt the earlier result.
- `n_rst` asserted during ROW1:
  - All outputs go to 0 at once and there is no `pixel_done` pulse.
  - After release, a fresh start completes normally with the correct value.

Source files
------------

// File: rtl/blur_pkg.sv
// Shared types, widths and helpers for the 3x3 Gaussian blur stage.
package blur_pkg;

  localparam int unsigned CH_W       = 8;
  localparam int unsigned PIX_W      = 24;
  localparam int unsigned ROW_W      = 72;
  localparam int unsigned WIN_W      = 216;
  localparam int unsigned ACC_W      = 12;
  localparam int unsigned GRAD_W     = 11;
  localparam int unsigned LUMA_SUM_W = 10;

  // Kernel 1 2 1 / 2 4 2 / 1 2 1 expressed as shifts: column weight, then extra row-1 weight.
  localparam int unsigned K_SIDE_SHIFT = 0;
  localparam int unsigned K_MID_SHIFT  = 1;
  localparam int unsigned K_ROW1_SHIFT = 1;
  localparam int unsigned RND_BIAS     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW0,
    ST_ROW1,
    ST_ROW2,
    ST_OUT
  } blur_state_t;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } pixel_t;

  function automatic logic [ROW_W-1:0] win_row(input logic [WIN_W-1:0] win,
                                               input logic [1:0]       row);
    case (row)
      2'd1:    return win[2*ROW_W-1 -: ROW_W];
      2'd2:    return win[3*ROW_W-1 -: ROW_W];
      default: return win[ROW_W-1:0];
    endcase
  endfunction

  // Rounded divide by 16; the sum cannot exceed 4088 so it never wraps.
  function automatic logic [CH_W-1:0] norm16(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] sum;
    sum = acc + ACC_W'(RND_BIAS);
    return sum[ACC_W-1 -: CH_W];
  endfunction

  function automatic logic [CH_W-1:0] luma(input pixel_t p);
    logic [LUMA_SUM_W-1:0] sum;
    sum = LUMA_SUM_W'(p.r) + (LUMA_SUM_W'(p.g) << 1) + LUMA_SUM_W'(p.b);
    return sum[LUMA_SUM_W-1 -: CH_W];
  endfunction

endpackage

// File: rtl/blur_filter_if.sv
// Read-buffer <-> blur stage handshake and result bus.
interface blur_filter_if;
  import blur_pkg::*;

  logic                filter_start;
  logic [WIN_W-1:0]    pixelData;
  logic                pixel_done;
  logic [PIX_W-1:0]    filtered_pixel;
  logic                filtered_valid;
  logic                edge_flag;
  logic                busy;

  modport master (
    output filter_start, pixelData,
    input  pixel_done, filtered_pixel, filtered_valid, edge_flag, busy
  );

  modport slave (
    input  filter_start, pixelData,
    output pixel_done, filtered_pixel, filtered_valid, edge_flag, busy
  );
endinterface

// File: rtl/channel_row_acc.sv
// One colour channel's row-by-row weighted accumulator (1,2,1 or 2,4,2 per row).
module channel_row_acc
  import blur_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             mid_row_i,
  input  logic [CH_W-1:0]  left_i,
  input  logic [CH_W-1:0]  ctr_i,
  input  logic [CH_W-1:0]  right_i,
  output logic [ACC_W-1:0] acc_next_o_c
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] row_sum_c;

  always_comb begin
    row_sum_c = (ACC_W'(left_i)  << K_SIDE_SHIFT)
              + (ACC_W'(ctr_i)   << K_MID_SHIFT)
              + (ACC_W'(right_i) << K_SIDE_SHIFT);
    if (mid_row_i) begin
      row_sum_c = row_sum_c << K_ROW1_SHIFT;
    end
    acc_next_o_c = acc_q;
    if (clr_i) begin
      acc_next_o_c = '0;
    end else if (en_i) begin
      acc_next_o_c = acc_q + row_sum_c;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_next_o_c;
    end
  end

endmodule

// File: rtl/blur_filter.sv
// 3x3 Gaussian blur over one captured window, one row per cycle, result after 4 cycles.
// Define BLUR_EDGE_EN to add the Sobel stage that forces edge pixels to black.
module blur_filter
  import blur_pkg::*;
#(
  parameter logic [GRAD_W-1:0] EDGE_THRESH = 11'd255
) (
  input  logic         clk,
  input  logic         n_rst,
  blur_filter_if.slave bus
);

  blur_state_t       state_q, state_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              acc_clr_c;
  logic              acc_en_c;
  logic              mid_row_c;
  logic [1:0]        row_idx_c;
  logic [ROW_W-1:0]  row_bits_c;
  pixel_t            px_l_c, px_m_c, px_r_c;
  logic [ACC_W-1:0]  acc_r_c, acc_g_c, acc_b_c;
  pixel_t            blur_c;
  pixel_t            pix_q, pix_d;
  logic              edge_q, edge_d;
  logic              busy_q;
  logic              done_q;

  // Sequencer: capture window, walk rows 0..2, present result for one cycle.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    acc_clr_c = 1'b0;
    acc_en_c  = 1'b0;
    row_idx_c = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (bus.filter_start) begin
          state_d   = ST_ROW0;
          win_d     = bus.pixelData;
          acc_clr_c = 1'b1;
        end
      end
      ST_ROW0: begin
        acc_en_c  = 1'b1;
        row_idx_c = 2'd0;
        state_d   = ST_ROW1;
      end
      ST_ROW1: begin
        acc_en_c  = 1'b1;
        row_idx_c = 2'd1;
        state_d   = ST_ROW2;
      end
      ST_ROW2: begin
        acc_en_c  = 1'b1;
        row_idx_c = 2'd2;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
    end
  end

  // Column 0 sits in the top 24 bits of each row.
  always_comb begin
    mid_row_c  = (row_idx_c == 2'd1);
    row_bits_c = win_row(win_q, row_idx_c);
    px_l_c     = pixel_t'(row_bits_c[ROW_W-1 -: PIX_W]);
    px_m_c     = pixel_t'(row_bits_c[2*PIX_W-1 -: PIX_W]);
    px_r_c     = pixel_t'(row_bits_c[PIX_W-1:0]);
  end

  channel_row_acc u_acc_r (
    .clk          (clk),
    .n_rst        (n_rst),
    .clr_i        (acc_clr_c),
    .en_i         (acc_en_c),
    .mid_row_i    (mid_row_c),
    .left_i       (px_l_c.r),
    .ctr_i        (px_m_c.r),
    .right_i      (px_r_c.r),
    .acc_next_o_c (acc_r_c)
  );

  channel_row_acc u_acc_g (
    .clk          (clk),
    .n_rst        (n_rst),
    .clr_i        (acc_clr_c),
    .en_i         (acc_en_c),
    .mid_row_i    (mid_row_c),
    .left_i       (px_l_c.g),
    .ctr_i        (px_m_c.g),
    .right_i      (px_r_c.g),
    .acc_next_o_c (acc_g_c)
  );

  channel_row_acc u_acc_b (
    .clk          (clk),
    .n_rst        (n_rst),
    .clr_i        (acc_clr_c),
    .en_i         (acc_en_c),
    .mid_row_i    (mid_row_c),
    .left_i       (px_l_c.b),
    .ctr_i        (px_m_c.b),
    .right_i      (px_r_c.b),
    .acc_next_o_c (acc_b_c)
  );

  assign blur_c = '{r: norm16(acc_r_c), g: norm16(acc_g_c), b: norm16(acc_b_c)};

`ifdef BLUR_EDGE_EN
  logic signed [GRAD_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic signed [GRAD_W-1:0] gx_term_c, gy_term_c;
  logic [CH_W-1:0]          y_l_c, y_m_c, y_r_c;
  logic [GRAD_W-1:0]        gy_row_c, gx_abs_c, gy_abs_c, grad_mag_c;

  // Sobel terms accumulate alongside the blur; magnitude uses the totals including row 2.
  always_comb begin
    y_l_c     = luma(px_l_c);
    y_m_c     = luma(px_m_c);
    y_r_c     = luma(px_r_c);
    gx_term_c = GRAD_W'(y_r_c) - GRAD_W'(y_l_c);
    if (mid_row_c) begin
      gx_term_c = gx_term_c <<< 1;
    end
    gy_row_c  = GRAD_W'(y_l_c) + (GRAD_W'(y_m_c) << 1) + GRAD_W'(y_r_c);
    gy_term_c = '0;
    if (row_idx_c == 2'd0) begin
      gy_term_c = GRAD_W'(0) - gy_row_c;
    end else if (row_idx_c == 2'd2) begin
      gy_term_c = gy_row_c;
    end
    gx_d = gx_q;
    gy_d = gy_q;
    if (acc_clr_c) begin
      gx_d = '0;
      gy_d = '0;
    end else if (acc_en_c) begin
      gx_d = gx_q + gx_term_c;
      gy_d = gy_q + gy_term_c;
    end
    gx_abs_c   = gx_d[GRAD_W-1] ? GRAD_W'(-gx_d) : GRAD_W'(gx_d);
    gy_abs_c   = gy_d[GRAD_W-1] ? GRAD_W'(-gy_d) : GRAD_W'(gy_d);
    grad_mag_c = gx_abs_c + gy_abs_c;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gx_q <= '0;
      gy_q <= '0;
    end else begin
      gx_q <= gx_d;
      gy_q <= gy_d;
    end
  end
`else
  // Threshold has no consumer without the edge stage.
  logic unused_thresh_c;
  assign unused_thresh_c = ^EDGE_THRESH;
`endif

  always_comb begin
    pix_d  = pix_q;
    edge_d = edge_q;
    if (state_q == ST_ROW2) begin
`ifdef BLUR_EDGE_EN
      if (grad_mag_c >= EDGE_THRESH) begin
        pix_d  = '0;
        edge_d = 1'b1;
      end else begin
        pix_d  = blur_c;
        edge_d = 1'b0;
      end
`else
      pix_d  = blur_c;
      edge_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pix_q  <= '0;
      edge_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pix_q  <= pix_d;
      edge_q <= edge_d;
      busy_q <= (state_d != ST_IDLE);
      done_q <= (state_d == ST_OUT);
    end
  end

  assign bus.filtered_pixel = pix_q;
  assign bus.edge_flag      = edge_q;
  assign bus.busy           = busy_q;
  assign bus.filtered_valid = done_q;
  assign bus.pixel_done     = done_q;

endmodule

// File: tb/tb_blur_filter.sv
// Self-checking bench for blur_filter: directed table, random windows vs. arithmetic model,
// back-to-back starts and mid-pixel reset. Honours BLUR_EDGE_EN like the design.
module tb_blur_filter;

  logic clk = 1'b0;
  logic n_rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  blur_filter_if bus();

  blur_filter dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [215:0] win;
    logic [23:0]  exp_pix;
    logic         exp_edge;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int px_shift(input int r, input int c);
    return 72 * r + 24 * (2 - c);
  endfunction

  function automatic logic [215:0] put_px(input logic [215:0] w, input int r, input int c,
                                          input logic [23:0] p);
    logic [215:0] mask;
    mask = 216'(24'hFFFFFF) << px_shift(r, c);
    return (w & ~mask) | (216'(p) << px_shift(r, c));
  endfunction

  function automatic logic [215:0] rand_win();
    logic [215:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w = put_px(w, r, c, 24'($urandom));
    return w;
  endfunction

  function automatic logic [215:0] smooth_win();
    logic [215:0] w = '0;
    logic [7:0]   br, bg, bb;
    br = 8'($urandom_range(0, 250));
    bg = 8'($urandom_range(0, 250));
    bb = 8'($urandom_range(0, 250));
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w = put_px(w, r, c, {br + 8'($urandom_range(0, 3)), bg + 8'($urandom_range(0, 3)),
                             bb + 8'($urandom_range(0, 3))});
    return w;
  endfunction

  // Reference: weighted 3x3 sum per channel, rounded /16; optional Sobel on luma.
  function automatic void model(input logic [215:0] w, output logic [23:0] pix,
                                output logic edg);
    int          acc[3];
    logic [23:0] p;
    int          wt;
    acc = '{0, 0, 0};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        p  = 24'(w >> px_shift(r, c));
        wt = ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1);
        acc[0] += wt * int'(p[23:16]);
        acc[1] += wt * int'(p[15:8]);
        acc[2] += wt * int'(p[7:0]);
      end
    pix = {8'((acc[0] + 8) / 16), 8'((acc[1] + 8) / 16), 8'((acc[2] + 8) / 16)};
    edg = 1'b0;
`ifdef BLUR_EDGE_EN
    begin
      int y[3][3];
      int gx, gy, mag;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          p = 24'(w >> px_shift(r, c));
          y[r][c] = (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
        end
      gx = 0;
      gy = 0;
      for (int k = 0; k < 3; k++) begin
        gx += ((k == 1) ? 2 : 1) * (y[k][2] - y[k][0]);
        gy += ((k == 1) ? 2 : 1) * (y[2][k] - y[0][k]);
      end
      mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
      if (mag >= 255) begin
        pix = 24'h000000;
        edg = 1'b1;
      end
    end
`endif
  endfunction

  // Entered #1 after a rising edge with the DUT idle; leaves #1 after edge N+5.
  task automatic do_pixel(input logic [215:0] w, output logic [23:0] pix, output logic edg,
                          output logic [4:0] done_sig, output logic [4:0] valid_sig,
                          output logic [4:0] busy_sig);
    bus.filter_start = 1'b1;
    bus.pixelData    = w;
    @(posedge clk); #1;
    bus.filter_start = 1'b0;
    bus.pixelData    = rand_win();
    pix = '0;
    edg = 1'b0;
    for (int i = 0; i < 5; i++) begin
      done_sig[i]  = bus.pixel_done;
      valid_sig[i] = bus.filtered_valid;
      busy_sig[i]  = bus.busy;
      if (i == 3) begin
        pix = bus.filtered_pixel;
        edg = bus.edge_flag;
      end
      @(posedge clk); #1;
    end
  endtask

  localparam logic [4:0] EXP_DONE = 5'b01000;
  localparam logic [4:0] EXP_BUSY = 5'b01111;

  initial begin
    vec_t         vecs[4];
    logic [23:0]  pix, mpix;
    logic         edg, medg;
    logic [4:0]   dsig, vsig, bsig;
    logic [215:0] w, w_a, w_b;
    logic [215:0] zero_win;
    logic [23:0]  left_exp;
    logic         left_edge;
    int           n_done;
    int           done_off[2];
    logic [23:0]  done_pix[2];
    logic         idle, seen_done;

    zero_win = '0;
`ifdef BLUR_EDGE_EN
    left_exp  = 24'h000000;
    left_edge = 1'b1;
`else
    left_exp  = 24'h404040;
    left_edge = 1'b0;
`endif
    vecs[0] = '{"uniform80", {9{24'h808080}}, 24'h808080, 1'b0};
    vecs[1] = '{"centre_white", put_px(zero_win, 1, 1, 24'hFFFFFF), 24'h404040, 1'b0};
    vecs[2] = '{"all_white", {9{24'hFFFFFF}}, 24'hFFFFFF, 1'b0};
    w = zero_win;
    for (int r = 0; r < 3; r++) w = put_px(w, r, 0, 24'hFFFFFF);
    vecs[3] = '{"left_col", w, left_exp, left_edge};

    n_rst            = 1'b0;
    bus.filter_start = 1'b0;
    bus.pixelData    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done",  32'(bus.pixel_done), 32'd0);
    check("rst_valid", 32'(bus.filtered_valid), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_pixel", 32'(bus.filtered_pixel), 32'd0);
    check("rst_edge",  32'(bus.edge_flag), 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      do_pixel(vecs[i].win, pix, edg, dsig, vsig, bsig);
      check({vecs[i].name, "_pix"},   32'(pix), 32'(vecs[i].exp_pix));
      check({vecs[i].name, "_edge"},  32'(edg), 32'(vecs[i].exp_edge));
      check({vecs[i].name, "_done"},  32'(dsig), 32'(EXP_DONE));
      check({vecs[i].name, "_valid"}, 32'(vsig), 32'(EXP_DONE));
      check({vecs[i].name, "_busy"},  32'(bsig), 32'(EXP_BUSY));
    end

    for (int i = 0; i < 40; i++) begin
      w = (i % 2 == 0) ? rand_win() : smooth_win();
      model(w, mpix, medg);
      do_pixel(w, pix, edg, dsig, vsig, bsig);
      check("rand_pix",  32'(pix), 32'(mpix));
      check("rand_edge", 32'(edg), 32'(medg));
      if (i % 8 == 0) check("rand_done", 32'(dsig), 32'(EXP_DONE));
    end

    // filter_start held for 12 sampling edges; window changes after each accept.
    w_a = rand_win();
    w_b = smooth_win();
    n_done = 0;
    done_off = '{0, 0};
    done_pix = '{24'h0, 24'h0};
    bus.filter_start = 1'b1;
    bus.pixelData    = w_a;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 0) bus.pixelData = w_b;
      if (i == 5) bus.pixelData = rand_win();
      if (bus.pixel_done) begin
        if (n_done < 2) begin
          done_off[n_done] = i + 1;
          done_pix[n_done] = bus.filtered_pixel;
        end
        n_done++;
      end
    end
    bus.filter_start = 1'b0;
    check("hold_count", 32'(n_done), 32'd2);
    check("hold_off0",  32'(done_off[0]), 32'd4);
    check("hold_off1",  32'(done_off[1]), 32'd9);
    model(w_a, mpix, medg);
    check("hold_pix0",  32'(done_pix[0]), 32'(mpix));
    model(w_b, mpix, medg);
    check("hold_pix1",  32'(done_pix[1]), 32'(mpix));
    idle = 1'b0;
    for (int k = 0; k < 20 && !idle; k++) begin
      if (!bus.busy) idle = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("hold_drain", 32'(idle), 32'd1);

    // Reset while the pixel is in ROW1.
    bus.filter_start = 1'b1;
    bus.pixelData    = {9{24'h808080}};
    @(posedge clk); #1;
    bus.filter_start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    n_rst = 1'b0;
    #1;
    check("mid_rst_busy",  32'(bus.busy), 32'd0);
    check("mid_rst_done",  32'(bus.pixel_done), 32'd0);
    check("mid_rst_valid", 32'(bus.filtered_valid), 32'd0);
    check("mid_rst_pixel", 32'(bus.filtered_pixel), 32'd0);
    check("mid_rst_edge",  32'(bus.edge_flag), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      seen_done = seen_done | bus.pixel_done | bus.busy;
    end
    check("post_rst_quiet", 32'(seen_done), 32'd0);
    w = smooth_win();
    model(w, mpix, medg);
    do_pixel(w, pix, edg, dsig, vsig, bsig);
    check("post_rst_pix",  32'(pix), 32'(mpix));
    check("post_rst_edge", 32'(edg), 32'(medg));
    check("post_rst_done", 32'(dsig), 32'(EXP_DONE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
